// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: state encoding and default width.
package shift_add_multiplier_pkg;

  // Default operand width; the product is twice this wide.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states. 2'd3 is unused and falls back to IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_multiplier_ripple_adder.sv
// Single-bit full adder cell and a WIDTH-bit ripple-carry adder chained from it.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module ripple_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Carry chain: w_carry[0] is the carry-in, w_carry[WIDTH] the carry-out.
  logic [WIDTH:0] w_carry;

  assign w_carry[0] = cin;
  assign cout       = w_carry[WIDTH];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      fulladder u_fa (
        .a    (a[gi]),
        .b    (b[gi]),
        .cin  (w_carry[gi]),
        .sum  (sum[gi]),
        .cout (w_carry[gi+1])
      );
    end
  endgenerate

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one add-and-shift step per clock, start/busy/done handshake.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t               r_state;
  logic [WIDTH-1:0]     r_a;
  // Partial-product accumulator. The bit above 2W-1 is always zero after
  // every step, so it is not stored.
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_product;

  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_cout;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic                 w_last;

  // Add the multiplicand only when the current multiplier bit is set.
  assign w_addend = r_acc[0] ? r_a : '0;

  ripple_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (r_acc[2*WIDTH-1:WIDTH]),
    .b    (w_addend),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Add then shift right by one; the carry-out lands in the top bit so it is never lost.
  assign w_acc_next = {w_cout, w_sum, r_acc[WIDTH-1:1]};
  assign w_last     = (r_count == CW'(WIDTH - 1));

  // Controller, step counter, accumulator and result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a     <= a;
            r_acc   <= {{WIDTH{1'b0}}, b};
            r_count <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_next;
          r_count <= r_count + CW'(1);
          if (w_last) begin
            r_product <= w_acc_next;
            r_state   <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign product = r_product;
  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: timing-level reference model plus directed and random operations.
module tb_shift_add_multiplier;

  localparam int W  = 8;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [PW-1:0] product;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted start yields W busy cycles, then a single
  // done cycle with product = a*b; a new start is accepted whenever not busy.
  int            m_busy_left = 0;
  logic          m_done = 1'b0;
  logic [PW-1:0] m_prod = '0;
  logic [PW-1:0] m_pend = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy_left <= 0;
      m_done      <= 1'b0;
      m_prod      <= '0;
    end else if (m_busy_left > 0) begin
      m_busy_left <= m_busy_left - 1;
      m_done      <= (m_busy_left == 1);
      if (m_busy_left == 1) m_prod <= m_pend;
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_pend      <= PW'(a) * PW'(b);
        m_busy_left <= W;
      end
    end
  end

  // Per-cycle comparison against the model, sampled away from the active edge.
  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_busy_left > 0));
    check("done", 32'(done), 32'(m_done));
    check("product", 32'(product), 32'(m_prod));
    check("busy_done_overlap", 32'(busy & done), 32'd0);
  end

  // Launch one operation from a negedge and wait (bounded) for done.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [31:0] exp, input string name);
    int lat;
    bit seen;
    a = ia;
    b = ib;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check({name, "_latency"}, 32'(lat), 32'(W + 1));
    check({name, "_product"}, 32'(product), exp);
  endtask

  initial begin
    int lat;
    bit seen;
    logic [W-1:0] ra, rb;

    // Reset state
    #1 reset = 1'b1;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases with hand-computed results
    run_op(8'd3, 8'd5, 32'd15, "3x5");
    repeat (3) @(negedge clk);
    check("3x5_held", 32'(product), 32'd15);
    run_op(8'd255, 8'd255, 32'd65025, "255x255");
    @(negedge clk);
    run_op(8'd0, 8'd200, 32'd0, "0x200");
    @(negedge clk);
    run_op(8'd200, 8'd0, 32'd0, "200x0");
    @(negedge clk);

    // start held high through RUN, operands disturbed mid-run, back-to-back start in DONE
    a = 8'd7;
    b = 8'd9;
    start = 1'b1;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      if (i == 4) begin
        a = 8'd100;
        b = 8'd3;
      end
    end
    @(negedge clk);
    check("7x9_done", 32'(done), 32'd1);
    check("7x9_product", 32'(product), 32'd63);
    a = 8'd2;
    b = 8'd4;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    lat = 1;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check("2x4_latency", 32'(lat), 32'(W + 1));
    check("2x4_product", 32'(product), 32'd8);
    @(negedge clk);

    // Asynchronous reset in the middle of an operation
    a = 8'd12;
    b = 8'd12;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_done", 32'(done), 32'd0);
    check("async_product", 32'(product), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("no_done_after_reset", 32'(done), 32'd0);
    end
    run_op(8'd12, 8'd12, 32'd144, "12x12");

    // Random sweep; gaps of 0 exercise back-to-back starts from DONE
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 9) == 0) ra = '1;
      if ($urandom_range(0, 9) == 0) rb = '1;
      run_op(ra, rb, 32'(ra) * 32'(rb), "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential unsigned multiplier: one WIDTH-bit add-and-shift step per clock.
- Sits directly downstream of the fulladder cell. It instantiates a WIDTH-bit ripple-carry adder built from fulladder cells, consumes that adder's sum/carry each cycle, and registers them into a partial-product accumulator.
- Start/busy/done handshake to the surrounding datapath; the final product is held until the next operation.

Parameters:
- WIDTH, 8, operand width in bits; must be >= 2. Product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a multiply; sampled only when state is IDLE or DONE
- a  input  WIDTH  multiplicand; captured on the accepted start edge
- b  input  WIDTH  multiplier; captured on the accepted start edge
- product  output  2*WIDTH  registered result; updated only when an operation completes
- busy  output  1  high while state is RUN
- done  output  1  one-cycle pulse, high while state is DONE

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset (any time, including mid-operation):
  - state goes to IDLE; product, busy, done and the step counter go to 0.
  - Any operation in progress is abandoned; no done pulse is produced for it.
- FSM states: IDLE, RUN, DONE. All outputs are registered or decoded from state only.
- IDLE:
  - start=1 at an edge: capture A_r<=a; load accumulator P[2W:0]<={1'b0, W'b0, b}; count<=0; go to RUN.
  - start=0: stay in IDLE.
- RUN, one step per edge:
  - Adder inputs: P[2W-1:W] and (P[0] ? A_r : 0), with cin=0. The adder produces a W-bit sum and a carry-out c.
  - Update: P <= {1'b0, c, sum, P[W-1:1]}. This is the add followed by a 1-bit right shift; the carry-out becomes the new bit 2W-1.
  - count increments. On the step where count==WIDTH-1: product<=next P[2W-1:0] and go to DONE.
  - start is ignored throughout RUN; a and b may change freely without effect.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - start=1: accept as in IDLE and go directly to RUN (back-to-back operation). Otherwise go to IDLE.
- Latency:
  - Start is accepted at edge E0. Steps occur at edges E1..EW. done is high in the cycle following EW.
  - busy is high from after E0 through EW.
- product holds its value through IDLE and RUN of the next operation, and changes only at the completion edge. This makes it safe to sample any time after done.
- Width rules:
  - Unsigned only; no overflow is possible, since max is (2^W-1)^2 < 2^(2W).
  - Counter width is clog2(WIDTH)+1.
  - The adder carry-out must never be dropped.
- Boundaries:
  - a=0 or b=0 yields 0 after the full WIDTH steps; there is no early termination.
  - All-ones operands exercise carry propagation through every cell.
  - start held high continuously gives back-to-back operations, each separated only by the single DONE cycle.

Decomposition:
- Shared package/header:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is illegal and must recover to IDLE.
  - default WIDTH constant.
- One sub-module: ripple_adder (parameter WIDTH; ports a, b, cin, sum, cout). It is a generate chain of fulladder instances.
- The multiplier's FSM, counter and accumulator live in shift_add_multiplier.

Test Plan:
- WIDTH=8, a=3, b=5, start pulse -> busy for 8 cycles; done pulse in the 9th cycle after the start edge; product=16'd15 and held after done.
- a=255, b=255 -> product=16'hFE01 (65025); checks full carry-chain propagation.
- a=0, b=200, then a=200, b=0 -> product=0 each time; done still arrives exactly 9 cycles after start.
- start=1 with a=7, b=9 held through RUN; a and b changed mid-RUN -> result 63 is unaffected; a second start in the DONE cycle with a=2, b=4 -> immediate RUN; product=8 exactly 9 cycles later.
- reset asserted asynchronously at step 4 of a=12, b=12 -> busy, done and product go to 0 immediately; no done pulse follows; a fresh 12*12 after release gives 144.
- Random sweep of 1000 operand pairs, compared against a*b reference -> zero mismatches; done is always one cycle wide and busy never coincides with done.
